// File: rtl/uart_rx_deframer_pkg.sv
// Shared UART receive definitions: FSM states, word-length codes, result payload.
package uart_rx_deframer_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_MWAIT = 3'd5
  } rx_state_t;

  typedef struct packed {
    logic [7:0] dout;
    logic       pe;
    logic       fe;
    logic       bi;
  } rx_result_t;

  // Index of the last data bit for a given word-length code (5..8 bits).
  function automatic logic [2:0] wls_last_idx(input logic [1:0] wls);
    return 3'(3'd4 + {1'b0, wls});
  endfunction

endpackage

// File: rtl/uart_rx_bitcnt.sv
// Baud-tick counter with mid-bit flag plus data-bit index with last-bit flag.
module uart_rx_bitcnt
  import uart_rx_deframer_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          i_clr,
  input  logic                          i_en,
  input  logic                          i_load,
  input  logic [$clog2(OVERSAMPLE)-1:0] i_load_val,
  input  logic                          i_bit_inc,
  input  logic [2:0]                    i_last_idx,
  output logic [$clog2(OVERSAMPLE)-1:0] o_count,
  output logic [2:0]                    o_bit_idx,
  output logic                          o_mid,
  output logic                          o_bit_last
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);

  logic [CW-1:0] r_count;
  logic [2:0]    r_bit_idx;
  logic          w_tc;

  assign w_tc       = (r_count == CW'(OVERSAMPLE - 1));
  assign o_mid      = (r_count == CW'(OVERSAMPLE / 2 - 1));
  assign o_bit_last = (r_bit_idx >= i_last_idx);
  assign o_count    = r_count;
  assign o_bit_idx  = r_bit_idx;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count   <= '0;
      r_bit_idx <= '0;
    end else if (i_clr) begin
      r_count   <= '0;
      r_bit_idx <= '0;
    end else if (i_en) begin
      if (i_load)     r_count <= i_load_val;
      else if (w_tc)  r_count <= '0;
      else            r_count <= r_count + CW'(1);
      if (i_bit_inc)  r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start/data/parity/stop recovery with error flags.
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXCLK,
  input  logic       CLEAR,
  input  logic       SIN,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  output logic [7:0] DOUT,
  output logic       PE,
  output logic       FE,
  output logic       BI,
  output logic       RXFINISHED
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);

  rx_state_t  r_state;
  logic [7:0] r_shift;
  logic       r_par_err;
  logic       r_par_bit;
  rx_result_t r_res;
  logic       r_rxfinished;

  logic [CW-1:0] w_count;
  logic [2:0]    w_bit_idx;
  logic          w_mid;
  logic          w_bit_last;
  logic          w_cnt_clr;
  logic          w_cnt_load;
  logic          w_bit_inc;
  logic          w_par_exp;
  logic          w_stb_unused;

  // Only the first stop bit is checked, so the stop-bit count has no effect.
  assign w_stb_unused = STB;

  assign w_cnt_clr  = CLEAR | (r_state == ST_IDLE) | (r_state == ST_MWAIT);
  assign w_cnt_load = (r_state == ST_START) & w_mid & ~SIN;
  assign w_bit_inc  = (r_state == ST_DATA) & w_mid;
  assign w_par_exp  = SP ? ~EPS : (^r_shift ^ ~EPS);

  uart_rx_bitcnt #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bitcnt (
    .CLK        (CLK),
    .RST        (RST),
    .i_clr      (w_cnt_clr),
    .i_en       (RXCLK),
    .i_load     (w_cnt_load),
    .i_load_val (CW'(OVERSAMPLE / 2)),
    .i_bit_inc  (w_bit_inc),
    .i_last_idx (wls_last_idx(WLS)),
    .o_count    (w_count),
    .o_bit_idx  (w_bit_idx),
    .o_mid      (w_mid),
    .o_bit_last (w_bit_last)
  );

  // Frame FSM; result registers publish together with the finish pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_par_bit    <= 1'b0;
      r_res        <= '0;
      r_rxfinished <= 1'b0;
    end else begin
      r_rxfinished <= 1'b0;
      if (CLEAR) begin
        r_state  <= ST_IDLE;
        r_res.pe <= 1'b0;
        r_res.fe <= 1'b0;
        r_res.bi <= 1'b0;
      end else if (RXCLK) begin
        case (r_state)
          ST_IDLE: begin
            if (!SIN) begin
              r_state   <= ST_START;
              r_shift   <= '0;
              r_par_err <= 1'b0;
              r_par_bit <= 1'b0;
            end
          end
          ST_START: begin
            if (w_mid) r_state <= SIN ? ST_IDLE : ST_DATA;
          end
          ST_DATA: begin
            if (w_mid) begin
              r_shift[w_bit_idx] <= SIN;
              if (w_bit_last) r_state <= PEN ? ST_PAR : ST_STOP;
            end
          end
          ST_PAR: begin
            if (w_mid) begin
              r_par_bit <= SIN;
              r_par_err <= (SIN != w_par_exp);
              r_state   <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (w_mid) begin
              r_res.dout   <= r_shift;
              r_res.pe     <= r_par_err;
              r_res.fe     <= ~SIN;
              r_res.bi     <= ~(|r_shift) & ~r_par_bit & ~SIN;
              r_rxfinished <= 1'b1;
              r_state      <= SIN ? ST_IDLE : ST_MWAIT;
            end
          end
          ST_MWAIT: begin
            if (SIN) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign DOUT       = r_res.dout;
  assign PE         = r_res.pe;
  assign FE         = r_res.fe;
  assign BI         = r_res.bi;
  assign RXFINISHED = r_rxfinished;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: directed frames, glitch, break, reset and clear aborts.
module tb_uart_rx_deframer;

  localparam int OVS = 16;

  typedef struct packed {
    logic [7:0] dout;
    logic       pe;
    logic       fe;
    logic       bi;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RXCLK = 1'b0;
  logic       CLEAR = 1'b0;
  logic       SIN = 1'b1;
  logic [1:0] WLS = 2'b11;
  logic       STB = 1'b0;
  logic       PEN = 1'b0;
  logic       EPS = 1'b0;
  logic       SP = 1'b0;
  logic [7:0] DOUT;
  logic       PE, FE, BI, RXFINISHED;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_pulses = 0;

  uart_rx_deframer #(.OVERSAMPLE(OVS)) dut (
    .CLK(CLK), .RST(RST), .RXCLK(RXCLK), .CLEAR(CLEAR), .SIN(SIN),
    .WLS(WLS), .STB(STB), .PEN(PEN), .EPS(EPS), .SP(SP),
    .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI), .RXFINISHED(RXFINISHED)
  );

  always #5 CLK = ~CLK;

  // Baud tick: one CLK high out of every three, so the FSM must hold between ticks.
  initial begin
    forever begin
      @(negedge CLK) RXCLK = 1'b1;
      @(negedge CLK) RXCLK = 1'b0;
      @(negedge CLK);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Monitor: every finish pulse must match the oldest expected result.
  always @(negedge CLK) begin
    if (RXFINISHED === 1'b1) begin
      exp_t e;
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got DOUT=0x%0h PE=%b FE=%b BI=%b, expected no pulse",
                 DOUT, PE, FE, BI);
      end else begin
        e = exp_q.pop_front();
        chk("dout", int'(DOUT), int'(e.dout));
        chk("pe",   int'(PE),   int'(e.pe));
        chk("fe",   int'(FE),   int'(e.fe));
        chk("bi",   int'(BI),   int'(e.bi));
      end
    end
  end

  task automatic wait_tick();
    do @(posedge CLK); while (RXCLK !== 1'b1);
  endtask

  task automatic hold_bit(input logic b, input int nticks);
    @(negedge CLK) SIN = b;
    repeat (nticks) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input logic has_par,
                            input logic par_bit, input logic stop_bit, input int nstop);
    hold_bit(1'b0, OVS);
    for (int i = 0; i < nbits; i++) hold_bit(data[i], OVS);
    if (has_par) hold_bit(par_bit, OVS);
    hold_bit(stop_bit, OVS);
    for (int i = 1; i < nstop; i++) hold_bit(1'b1, OVS);
    hold_bit(1'b1, 6);
  endtask

  task automatic cfg(input logic [1:0] wls, input logic pen, input logic eps,
                     input logic sp, input logic stb);
    @(negedge CLK);
    WLS = wls; PEN = pen; EPS = eps; SP = sp; STB = stb;
  endtask

  initial begin
    int p0;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_dout", int'(DOUT), 0);
    chk("rst_pe",   int'(PE), 0);
    chk("rst_fe",   int'(FE), 0);
    chk("rst_bi",   int'(BI), 0);
    chk("rst_fin",  int'(RXFINISHED), 0);
    hold_bit(1'b1, 4);

    // 8N1 0xA5
    cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1);

    // 5E1 data 0x13 (three ones): correct even parity is 1
    cfg(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back('{8'h13, 1'b1, 1'b0, 1'b0});
    send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1, 1);
    exp_q.push_back('{8'h13, 1'b0, 1'b0, 1'b0});
    send_frame(8'h13, 5, 1'b1, 1'b1, 1'b1, 1);

    // Stick parity, EPS=0: parity bit must be 1
    cfg(2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back('{8'h5A, 1'b1, 1'b0, 1'b0});
    send_frame(8'h5A, 8, 1'b1, 1'b0, 1'b1, 1);
    exp_q.push_back('{8'h5A, 1'b0, 1'b0, 1'b0});
    send_frame(8'h5A, 8, 1'b1, 1'b1, 1'b1, 1);

    // 7O2 data 0x41 (two ones): odd parity bit is 1
    cfg(2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_q.push_back('{8'h41, 1'b0, 1'b0, 1'b0});
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 2);

    // 6N1 0x2B
    cfg(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('{8'h2B, 1'b0, 1'b0, 1'b0});
    send_frame(8'h2B, 6, 1'b0, 1'b0, 1'b1, 1);

    // Start-bit glitch of three ticks: no pulse
    cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    p0 = n_pulses;
    hold_bit(1'b0, 3);
    hold_bit(1'b1, 40);
    chk("glitch_pulses", n_pulses - p0, 0);
    exp_q.push_back('{8'hE7, 1'b0, 1'b0, 1'b0});
    send_frame(8'hE7, 8, 1'b0, 1'b0, 1'b1, 1);

    // Break: line low for two 8E1 frame times
    cfg(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    p0 = n_pulses;
    exp_q.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
    hold_bit(1'b0, 2 * 11 * OVS);
    chk("break_pulses", n_pulses - p0, 1);
    hold_bit(1'b1, 20);
    exp_q.push_back('{8'h96, 1'b0, 1'b0, 1'b0});
    send_frame(8'h96, 8, 1'b1, 1'b0, 1'b1, 1);

    // Reset in the middle of data bit 4
    cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    p0 = n_pulses;
    hold_bit(1'b0, OVS);
    for (int i = 0; i < 4; i++) hold_bit(1'b1, OVS);
    hold_bit(1'b0, OVS / 2);
    @(negedge CLK);
    RST = 1'b1; SIN = 1'b1;
    @(negedge CLK);
    chk("rst_mid_dout", int'(DOUT), 0);
    chk("rst_mid_pe",   int'(PE), 0);
    chk("rst_mid_fe",   int'(FE), 0);
    chk("rst_mid_bi",   int'(BI), 0);
    chk("rst_mid_fin",  int'(RXFINISHED), 0);
    RST = 1'b0;
    hold_bit(1'b1, 3 * OVS);
    chk("rst_mid_pulses", n_pulses - p0, 0);
    exp_q.push_back('{8'h3C, 1'b0, 1'b0, 1'b0});
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1);

    // Framing error leaves FE set, then CLEAR in the middle of data bit 4
    exp_q.push_back('{8'h81, 1'b0, 1'b1, 1'b0});
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1);
    hold_bit(1'b1, 10);
    p0 = n_pulses;
    hold_bit(1'b0, OVS);
    for (int i = 0; i < 4; i++) hold_bit(1'b0, OVS);
    hold_bit(1'b1, OVS / 2);
    @(negedge CLK);
    CLEAR = 1'b1; SIN = 1'b1;
    @(negedge CLK);
    CLEAR = 1'b0;
    chk("clr_dout", int'(DOUT), 32'h81);
    chk("clr_pe",   int'(PE), 0);
    chk("clr_fe",   int'(FE), 0);
    chk("clr_bi",   int'(BI), 0);
    chk("clr_fin",  int'(RXFINISHED), 0);
    hold_bit(1'b1, 12 * OVS);
    chk("clr_pulses", n_pulses - p0, 0);
    exp_q.push_back('{8'hC3, 1'b0, 1'b0, 1'b0});
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1);

    hold_bit(1'b1, 10);
    chk("pending_expected", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

Interface
REQ-001 Parameter OVERSAMPLE, default 16, baud ticks per bit; legal values are even and at least 8.
REQ-002 CLK  in  1  system clock; all state changes on its rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 RXCLK  in  1  baud-tick enable, one CLK wide, OVERSAMPLE per bit time.
REQ-005 CLEAR  in  1  synchronous abort: return to IDLE, flags cleared.
REQ-006 SIN  in  1  serial input, already two-flop synchronised upstream.
REQ-007 WLS  in  2  word length: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-008 STB  in  1  stop bits (1 or 2); the receiver checks only the first stop bit.
REQ-009 PEN, EPS, SP  in  1 each  parity enable, even parity select, stick parity.
REQ-010 DOUT  out  8  received word, LSB-aligned; unused upper bits are 0.
REQ-011 PE, FE, BI  out  1 each  parity error, framing error, break indication for DOUT.
REQ-012 RXFINISHED  out  1  one-CLK pulse: DOUT/PE/FE/BI valid and stable.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PAR, STOP, MWAIT.
- Tick counter: 0..OVERSAMPLE-1, advances only on RXCLK.
- Mid-bit sample point: count == OVERSAMPLE/2-1.
REQ-014 IDLE: on RXCLK with SIN=0, go to START, counter=0, bit index=0.
REQ-015 START: at mid-bit, SIN=0 -> DATA with the counter realigned to bit start; SIN=1 -> IDLE (glitch rejected, no pulse).
REQ-016 DATA: at each mid-bit, shift SIN in LSB-first.
- After 5+WLS bits -> PAR if PEN=1, else STOP.
REQ-017 PAR: at mid-bit, capture the parity bit.
- Expected parity: SP=0 gives XOR(data) XOR ~EPS; SP=1 gives ~EPS.
- PE=1 on mismatch, else PE=0.
REQ-018 STOP: at mid-bit, FE = ~SIN.
- BI=1 iff all data bits, the parity bit (if present) and the stop bit sampled 0.
- RXFINISHED pulses in the cycle after the stop sample; DOUT/PE/FE/BI are updated the same cycle.
REQ-019 After STOP: SIN=1 -> IDLE; SIN=0 -> MWAIT.
- MWAIT holds until SIN=1 is seen on an RXCLK, then IDLE; no new start is recognised while in MWAIT.
REQ-020 DOUT/PE/FE/BI SHALL hold their last values until the next RXFINISHED.
REQ-021 WLS/PEN/EPS/SP/STB changes mid-frame: the frame is undefined, but the FSM SHALL return to IDLE within one frame time plus MWAIT.
REQ-022 RXCLK low SHALL freeze the FSM and counters; RXFINISHED is never asserted without a preceding RXCLK.
REQ-023 CLEAR has priority over RXCLK in the same cycle.
- CLEAR forces IDLE, counter=0, PE/FE/BI=0, RXFINISHED=0; DOUT is kept.

Reset
REQ-024 RST SHALL force IDLE, counters 0, shift register 0, DOUT=8'h00, PE=FE=BI=0, RXFINISHED=0.
REQ-025 RST asserted mid-frame SHALL take effect immediately; no partial-word pulse is produced after release.

Structure
REQ-026 The state enumeration and WLS encoding constants SHALL live in the shared UART package; the OVERSAMPLE default SHALL also be defined there.
REQ-027 The tick/bit counter SHALL be one sub-module, uart_rx_bitcnt: load, enable, terminal-count flags.
REQ-028 Outputs SHALL be registered; no combinational path from SIN to any output.

Verification
REQ-029 WLS=11, PEN=0, byte 8'hA5 at 16x -> one RXFINISHED, DOUT=8'hA5, PE=FE=BI=0.
REQ-030 WLS=00, PEN=1, EPS=1, data 5'h13 with wrong parity bit -> DOUT=8'h13, PE=1, FE=0.
REQ-031 SP=1, EPS=0, parity bit sampled 0 -> PE=1; same frame with parity bit 1 -> PE=0.
REQ-032 SIN low for 3 ticks then high -> no RXFINISHED, FSM back in IDLE.
REQ-033 SIN held 0 for 2 frame times, WLS=11, PEN=1 -> one pulse with DOUT=8'h00, FE=1, BI=1.
- Then no further pulse until SIN=1; the next valid frame is received correctly.
REQ-034 RST pulse during bit 4 of a frame -> all outputs 0; a subsequent frame 8'h3C is received correctly.
REQ-035 CLEAR during bit 4 of a frame -> no pulse for the aborted frame; outputs per REQ-023.
